// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Holds the NOP encoding, the PC step, the fetch states and the queue entry layout.
package instruction_fetch_queue_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_INCR   = 32'd4;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } ifq_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Instruction-memory and decode-side signals of the fetch queue.
// master: the fetch queue itself; slave: memory, execute and decode around it.
interface instruction_fetch_queue_if;

   logic [31:0] IMEM_ADDR;
   logic        IMEM_READ;
   logic        IMEM_BUSYWAIT;
   logic [31:0] IMEM_READDATA;
   logic        BRANCH_TAKEN;
   logic [31:0] BRANCH_TARGET;
   logic        DECODE_STALL;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC_OUT;
   logic        VALID;

   modport master (
      output IMEM_ADDR, IMEM_READ, INSTRUCTION, PC_OUT, VALID,
      input  IMEM_BUSYWAIT, IMEM_READDATA, BRANCH_TAKEN, BRANCH_TARGET, DECODE_STALL
   );

   modport slave (
      input  IMEM_ADDR, IMEM_READ, INSTRUCTION, PC_OUT, VALID,
      output IMEM_BUSYWAIT, IMEM_READDATA, BRANCH_TAKEN, BRANCH_TARGET, DECODE_STALL
   );

endinterface

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// Circular prefetch buffer of {PC, INSTR} entries with flush and combinational head.
// DEPTH must be a power of two (>= 2) so the pointers wrap by plain overflow.
module fetch_fifo
   import instruction_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             wr_entry,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   fetch_entry_t    mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A push into a full buffer only happens alongside a pop, so it reuses the head slot.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wr_entry;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues busywait reads, buffers words for decode.
// Optional IFQ_PERF_COUNT_EN adds FETCH_COUNT / DISCARD_COUNT outputs.
module instruction_fetch_queue
   import instruction_fetch_queue_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic                      CLK,
   input  logic                      RESET,
   instruction_fetch_queue_if.master bus
`ifdef IFQ_PERF_COUNT_EN
   ,
   output logic [31:0]               FETCH_COUNT,
   output logic [31:0]               DISCARD_COUNT
`endif
);

   ifq_state_e                  state, state_nxt;
   logic [31:0]                 fetch_pc, fetch_pc_nxt;
   logic [31:0]                 redirect_pc, redirect_nxt;
   logic [31:0]                 target;
   logic                        imem_read;
   logic                        push;
   logic                        pop;
   logic                        dropped;
   fetch_entry_t                head;
   fetch_entry_t                wr_entry;
   logic [$clog2(DEPTH):0]      count;
   logic                        full;
   logic                        empty;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (CLK),
      .rst_n    (RESET),
      .push     (push),
      .pop      (pop),
      .flush    (bus.BRANCH_TAKEN),
      .wr_entry (wr_entry),
      .head     (head),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign target   = {bus.BRANCH_TARGET[31:2], 2'b00};
   assign pop      = !empty && !bus.DECODE_STALL;
   assign wr_entry = '{pc: fetch_pc, instr: bus.IMEM_READDATA};

   // Request is gated by RESET so it drops the instant reset asserts.
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      redirect_nxt = redirect_pc;
      imem_read    = 1'b0;
      push         = 1'b0;
      dropped      = 1'b0;
      case (state)
         FETCH: begin
            imem_read = RESET && (!full || pop);
            if (bus.BRANCH_TAKEN) begin
               if (imem_read && bus.IMEM_BUSYWAIT) begin
                  redirect_nxt = target;
                  state_nxt    = DISCARD;
               end else begin
                  fetch_pc_nxt = target;
                  dropped      = imem_read;
               end
            end else if (imem_read && !bus.IMEM_BUSYWAIT) begin
               push         = 1'b1;
               fetch_pc_nxt = fetch_pc + PC_INCR;
            end
         end
         DISCARD: begin
            imem_read = 1'b1;
            if (bus.BRANCH_TAKEN) redirect_nxt = target;
            if (!bus.IMEM_BUSYWAIT) begin
               fetch_pc_nxt = redirect_nxt;
               dropped      = 1'b1;
               state_nxt    = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         redirect_pc <= '0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         redirect_pc <= redirect_nxt;
      end
   end

   assign bus.IMEM_ADDR   = fetch_pc;
   assign bus.IMEM_READ   = imem_read;
   assign bus.VALID       = !empty;
   assign bus.INSTRUCTION = empty ? NOP_INSTR : head.instr;
   assign bus.PC_OUT      = empty ? '0 : head.pc;

`ifdef IFQ_PERF_COUNT_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         FETCH_COUNT   <= '0;
         DISCARD_COUNT <= '0;
      end else begin
         if (push) FETCH_COUNT <= FETCH_COUNT + 32'd1;
         DISCARD_COUNT <= DISCARD_COUNT + 32'(dropped)
                        + (bus.BRANCH_TAKEN ? 32'(count) : 32'd0);
      end
   end
`else
   logic unused_perf;
   assign unused_perf = ^{count, dropped};
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomised bench for instruction_fetch_queue against a queue-based reference model.
// Optional IFQ_PERF_COUNT_EN also checks the performance counters.
module tb_instruction_fetch_queue;
   import instruction_fetch_queue_pkg::*;

   localparam logic [31:0] KEY    = 32'hA5A5_0000;
   localparam int unsigned DEPTH0 = 2;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;
   int   checks = 0;
   int   errors = 0;

   instruction_fetch_queue_if if0 ();
   instruction_fetch_queue_if if1 ();

   assign if0.IMEM_READDATA = if0.IMEM_ADDR ^ KEY;
   assign if1.IMEM_READDATA = if1.IMEM_ADDR ^ KEY;
   assign if1.IMEM_BUSYWAIT = if0.IMEM_BUSYWAIT;
   assign if1.BRANCH_TAKEN  = if0.BRANCH_TAKEN;
   assign if1.BRANCH_TARGET = if0.BRANCH_TARGET;
   assign if1.DECODE_STALL  = if0.DECODE_STALL;

`ifdef IFQ_PERF_COUNT_EN
   logic [31:0] fc0, dc0, fc1, dc1;
`endif

   instruction_fetch_queue #(.RESET_PC(32'h0000_0100), .DEPTH(DEPTH0)) u0 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if0)
`ifdef IFQ_PERF_COUNT_EN
      ,
      .FETCH_COUNT   (fc0),
      .DISCARD_COUNT (dc0)
`endif
   );

   instruction_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u1 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if1)
`ifdef IFQ_PERF_COUNT_EN
      ,
      .FETCH_COUNT   (fc1),
      .DISCARD_COUNT (dc1)
`endif
   );

   always #5 CLK = ~CLK;

   // Reference model: queue of {pc, instr}, fetch address, and a pending-discard flag.
   logic [63:0] m_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_redir;
   bit          m_discard;
   logic [31:0] m_fc;
   logic [31:0] m_dc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc      = 32'h0000_0100;
      m_redir   = '0;
      m_discard = 0;
      m_fc      = '0;
      m_dc      = '0;
   endtask

   task automatic compare(input bit stall);
      bit          valid = (m_q.size() != 0);
      bit          pop   = valid && !stall;
      bit          rd    = m_discard || (m_q.size() < DEPTH0) || pop;
      logic [63:0] h     = valid ? m_q[0] : {32'h0, NOP_INSTR};
      chk("valid", {31'b0, if0.VALID}, {31'b0, valid});
      chk("instruction", if0.INSTRUCTION, h[31:0]);
      chk("pc_out", if0.PC_OUT, h[63:32]);
      chk("imem_read", {31'b0, if0.IMEM_READ}, {31'b0, rd});
      if (rd) chk("imem_addr", if0.IMEM_ADDR, m_pc);
`ifdef IFQ_PERF_COUNT_EN
      chk("fetch_count", fc0, m_fc);
      chk("discard_count", dc0, m_dc);
`endif
   endtask

   task automatic model_update(input bit stall, input bit busy, input bit br, input logic [31:0] tgt);
      bit          valid = (m_q.size() != 0);
      bit          pop   = valid && !stall;
      bit          rd    = m_discard || (m_q.size() < DEPTH0) || pop;
      bit          done  = rd && !busy;
      logic [31:0] t     = {tgt[31:2], 2'b00};
      if (m_discard) begin
         if (br) m_redir = t;
         if (done) begin
            m_pc      = m_redir;
            m_discard = 0;
            m_dc++;
         end
      end else if (br) begin
         m_dc += m_q.size();
         m_q.delete();
         if (rd && busy) begin
            m_discard = 1;
            m_redir   = t;
         end else begin
            m_pc = t;
            if (done) m_dc++;
         end
      end else begin
         if (pop) void'(m_q.pop_front());
         if (done) begin
            m_q.push_back({m_pc, m_pc ^ KEY});
            m_pc += 32'd4;
            m_fc++;
         end
      end
   endtask

   // Called at a falling edge; returns at the next falling edge after the model step.
   task automatic step(input bit stall, input bit busy, input bit br, input logic [31:0] tgt);
      if0.DECODE_STALL  = stall;
      if0.IMEM_BUSYWAIT = busy;
      if0.BRANCH_TAKEN  = br;
      if0.BRANCH_TARGET = tgt;
      #1;
      compare(stall);
      model_update(stall, busy, br, tgt);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      #1;
      chk("rst_read", {31'b0, if0.IMEM_READ}, 32'd0);
      chk("rst_valid", {31'b0, if0.VALID}, 32'd0);
      chk("rst_instr", if0.INSTRUCTION, 32'h0000_0013);
      chk("rst_pc_out", if0.PC_OUT, 32'd0);
`ifdef IFQ_PERF_COUNT_EN
      chk("rst_fetch_count", fc0, 32'd0);
      chk("rst_discard_count", dc0, 32'd0);
`endif
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   logic [31:0] old_pc;

   initial begin
      if0.DECODE_STALL  = 1'b0;
      if0.IMEM_BUSYWAIT = 1'b0;
      if0.BRANCH_TAKEN  = 1'b0;
      if0.BRANCH_TARGET = '0;
      do_reset();
      #1;
      chk("wrap_addr0", if1.IMEM_ADDR, 32'hFFFF_FFF8);

      // Zero-wait streaming from RESET_PC.
      step(0, 0, 0, 0);
      chk("first_valid", {31'b0, if0.VALID}, 32'd1);
      chk("first_pc", if0.PC_OUT, 32'h0000_0100);
      chk("first_instr", if0.INSTRUCTION, 32'hA5A5_0100);
      chk("second_addr", if0.IMEM_ADDR, 32'h0000_0104);
      chk("wrap_addr1", if1.IMEM_ADDR, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      chk("wrap_addr2", if1.IMEM_ADDR, 32'h0000_0000);
      chk("wrap_pc1", if1.PC_OUT, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      chk("wrap_pc2", if1.PC_OUT, 32'h0000_0000);

      // Decode stall: outputs frozen, fetch stops once full.
      repeat (5) step(1, 0, 0, 0);
      chk("stall_pc", if0.PC_OUT, 32'h0000_0108);
      chk("stall_read", {31'b0, if0.IMEM_READ}, 32'd0);
      repeat (4) step(0, 0, 0, 0);

      // Branch while an access is pending, memory busy three more cycles.
      old_pc = m_pc;
      step(0, 1, 1, 32'h0000_2000);
      chk("br_valid", {31'b0, if0.VALID}, 32'd0);
      repeat (3) step(0, 1, 0, 0);
      chk("br_hold_addr", if0.IMEM_ADDR, old_pc);
      step(0, 0, 0, 0);
      chk("br_new_addr", if0.IMEM_ADDR, 32'h0000_2000);
      chk("br_valid2", {31'b0, if0.VALID}, 32'd0);
      step(0, 0, 0, 0);
      chk("br_first_pc", if0.PC_OUT, 32'h0000_2000);

      // Branch on a completing cycle with a full queue and a pop.
      repeat (3) step(1, 0, 0, 0);
      step(0, 0, 1, 32'h0000_3003);
      chk("flush_valid", {31'b0, if0.VALID}, 32'd0);
      chk("flush_addr", if0.IMEM_ADDR, 32'h0000_3000);

      // Randomised traffic.
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
              $urandom_range(0, 99) < 8, $urandom());
      end

      // Asynchronous reset in the middle of a busy access.
      step(0, 1, 0, 0);
      #2;
      do_reset();
      step(0, 0, 0, 0);
      chk("restart_pc", if0.PC_OUT, 32'h0000_0100);
      repeat (20) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
